// File: rtl/step_sequencer.sv
// step_sequencer: 16-step, 12-note pattern sequencer feeding audio_generator.
// Holds one note mask per step, walks the steps at a programmable tempo and
// drives audio_generator's Select / nStart. The pattern can be edited at any
// time through the WrEn/WrStep/WrNotes port.
`timescale 1ns/1ps

module step_sequencer #(
  parameter int STEPS  = 16,
  parameter int STEP_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Pause,
  input  logic              Stop,
  input  logic              Loop,
  input  logic [CNT_W-1:0]  StepPeriod,
  input  logic              WrEn,
  input  logic [STEP_W-1:0] WrStep,
  input  logic [11:0]       WrNotes,
  output logic [11:0]       Select,
  output logic              nStart,
  output logic [STEP_W-1:0] Step,
  output logic              StepPulse,
  output logic              Playing
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  period;
  logic [11:0]       pattern [STEPS];

  logic [CNT_W-1:0]  eff_period;
  logic              expire;
  logic              last_step;
  logic [STEP_W-1:0] next_step;
  logic [STEP_W-1:0] rd_idx;
  logic [11:0]       rd_notes;
  logic              to_idle;

  // Pattern store: written in every state, cleared by reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: the pattern array is reset on purpose; a reset mid-play must
      // leave a silent pattern, so this cannot be plain RAM.
      for (int i = 0; i < STEPS; i++) begin
        pattern[i] <= '0;
      end
    end else if (WrEn) begin
      pattern[WrStep] <= WrNotes;
    end
  end

  // Step timing, the note mask for the step being entered, and idle exits.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch is inferred.
    eff_period = (StepPeriod == '0) ? CNT_W'(1) : StepPeriod;
    expire     = (count == period - CNT_W'(1));
    last_step  = (Step == STEP_W'(STEPS - 1));
    next_step  = Step + STEP_W'(1);
    rd_idx     = '0;
    to_idle    = 1'b0;

    // IDLE enters step 0, RUN enters the following step, PAUSED resumes the held step.
    case (state)
      ST_RUN:    rd_idx = next_step;
      ST_PAUSED: rd_idx = Step;
      default:   rd_idx = '0;
    endcase

    // Write-first: a write landing on the step being entered wins over the store.
    rd_notes = (WrEn && (WrStep == rd_idx)) ? WrNotes : pattern[rd_idx];

    if (state != ST_IDLE) begin
      if (Stop) begin
        to_idle = 1'b1;
      end else if ((state == ST_RUN) && !Pause && expire && last_step && !Loop) begin
        to_idle = 1'b1;
      end
    end
  end

  // Sequencer control: state, tempo counter, step index and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      period    <= '0;
      Step      <= '0;
      Select    <= '0;
      nStart    <= 1'b0;
      StepPulse <= 1'b0;
      Playing   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every read sees
      // the pre-edge value and the default below can be overridden safely.
      StepPulse <= 1'b0;
      if (to_idle) begin
        state   <= ST_IDLE;
        count   <= '0;
        period  <= '0;
        Step    <= '0;
        Select  <= '0;
        nStart  <= 1'b0;
        Playing <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Stop has priority, Pause is meaningless here.
            if (!Stop && Start) begin
              state     <= ST_RUN;
              count     <= '0;
              period    <= eff_period;
              Step      <= '0;
              Select    <= rd_notes;
              StepPulse <= 1'b1;
              nStart    <= 1'b1;
              Playing   <= 1'b1;
            end
          end
          ST_RUN: begin
            if (Pause) begin
              state   <= ST_PAUSED;
              Select  <= '0;
              Playing <= 1'b0;
            end else if (expire) begin
              count     <= '0;
              period    <= eff_period;
              Step      <= next_step;
              Select    <= rd_notes;
              StepPulse <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          ST_PAUSED: begin
            // Resume keeps the held counter and gives no step pulse.
            if (Start) begin
              state   <= ST_RUN;
              Select  <= rd_notes;
              Playing <= 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            count   <= '0;
            period  <= '0;
            Step    <= '0;
            Select  <= '0;
            nStart  <= 1'b0;
            Playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer: directed scenarios followed by a random
// phase, every cycle compared against a step-duration reference model.
`timescale 1ns/1ps

module tb_step_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start, Pause, Stop, Loop;
  logic [31:0] StepPeriod;
  logic        WrEn;
  logic [3:0]  WrStep;
  logic [11:0] WrNotes;
  logic [11:0] Select;
  logic        nStart;
  logic [3:0]  Step;
  logic        StepPulse;
  logic        Playing;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode, current step, cycles spent in it, its length.
  typedef enum int {M_IDLE, M_RUN, M_PAUSED} mode_t;
  mode_t       m_mode;
  logic [11:0] m_pat [16];
  int          m_step;
  int          m_elapsed;
  int          m_len;
  logic [11:0] m_sel;
  bit          m_pulse;

  step_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Pause      (Pause),
    .Stop       (Stop),
    .Loop       (Loop),
    .StepPeriod (StepPeriod),
    .WrEn       (WrEn),
    .WrStep     (WrStep),
    .WrNotes    (WrNotes),
    .Select     (Select),
    .nStart     (nStart),
    .Step       (Step),
    .StepPulse  (StepPulse),
    .Playing    (Playing)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_step = 0;
    m_elapsed = 0;
    m_len = 1;
    m_sel = '0;
    m_pulse = 1'b0;
    for (int i = 0; i < 16; i++) m_pat[i] = '0;
  endtask

  task automatic model_go_idle();
    m_mode = M_IDLE;
    m_step = 0;
    m_elapsed = 0;
    m_sel = '0;
  endtask

  task automatic model_enter(input int k);
    m_step = k % 16;
    m_elapsed = 0;
    m_len = (StepPeriod == 0) ? 1 : int'(StepPeriod);
    m_sel = m_pat[m_step];
    m_pulse = 1'b1;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at that edge.
  task automatic model_update();
    if (WrEn) m_pat[WrStep] = WrNotes;  // written before any read: write-first
    m_pulse = 1'b0;
    if (Stop) begin
      model_go_idle();
    end else begin
      case (m_mode)
        M_IDLE: if (Start) begin
          m_mode = M_RUN;
          model_enter(0);
        end
        M_RUN: begin
          if (Pause) begin
            m_mode = M_PAUSED;
            m_sel = '0;
          end else if (m_elapsed + 1 >= m_len) begin
            if (m_step == 15 && !Loop) model_go_idle();
            else model_enter(m_step + 1);
          end else begin
            m_elapsed++;
          end
        end
        M_PAUSED: if (Start) begin
          m_mode = M_RUN;
          m_sel = m_pat[m_step];
        end
        default: model_go_idle();
      endcase
    end
  endtask

  task automatic check_model();
    check("Select",    32'(Select),    32'(m_sel));
    check("nStart",    32'(nStart),    32'(m_mode != M_IDLE));
    check("Step",      32'(Step),      32'(m_step));
    check("StepPulse", 32'(StepPulse), 32'(m_pulse));
    check("Playing",   32'(Playing),   32'(m_mode == M_RUN));
  endtask

  // Apply the prepared inputs for one edge, then compare on the falling edge.
  task automatic tick();
    @(posedge Clock);
    if (Reset) model_reset();
    else model_update();
    @(negedge Clock);
    check_model();
    Start = 1'b0;
    Pause = 1'b0;
    Stop  = 1'b0;
    WrEn  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_pat(input int idx, input logic [11:0] val);
    WrEn = 1'b1;
    WrStep = 4'(idx);
    WrNotes = val;
    tick();
  endtask

  logic [11:0] old5;

  initial begin
    Reset = 1'b1;
    Start = 1'b0; Pause = 1'b0; Stop = 1'b0; Loop = 1'b1;
    StepPeriod = 32'd4;
    WrEn = 1'b0; WrStep = '0; WrNotes = '0;
    model_reset();
    #3;
    check("reset_Select",    32'(Select),    32'h0);
    check("reset_nStart",    32'(nStart),    32'h0);
    check("reset_Step",      32'(Step),      32'h0);
    check("reset_StepPulse", 32'(StepPulse), 32'h0);
    check("reset_Playing",   32'(Playing),   32'h0);
    @(negedge Clock);
    Reset = 1'b0;

    // Pattern load: steps 0 and 1 fixed, the rest random.
    write_pat(0, 12'h001);
    write_pat(1, 12'h090);
    for (int i = 2; i < 16; i++) write_pat(i, 12'($urandom));

    // Looping playback at period 4.
    Loop = 1'b1; StepPeriod = 32'd4; Start = 1'b1;
    tick();
    check("start_Select",    32'(Select),    32'h001);
    check("start_Step",      32'(Step),      32'h0);
    check("start_StepPulse", 32'(StepPulse), 32'h1);
    check("start_nStart",    32'(nStart),    32'h1);
    ticks(4);
    check("step1_Select", 32'(Select), 32'h090);
    check("step1_Step",   32'(Step),   32'h1);
    ticks(60);
    check("wrap_Step",      32'(Step),      32'h0);
    check("wrap_StepPulse", 32'(StepPulse), 32'h1);
    check("wrap_Select",    32'(Select),    32'h001);
    Stop = 1'b1;
    tick();

    // One-shot playback at period 2 ends in IDLE after 32 cycles.
    Loop = 1'b0; StepPeriod = 32'd2; Start = 1'b1;
    tick();
    ticks(31);
    check("oneshot_last_Step",    32'(Step),    32'd15);
    check("oneshot_last_Playing", 32'(Playing), 32'h1);
    tick();
    check("oneshot_end_Select",  32'(Select),  32'h0);
    check("oneshot_end_nStart",  32'(nStart),  32'h0);
    check("oneshot_end_Playing", 32'(Playing), 32'h0);
    check("oneshot_end_Step",    32'(Step),    32'h0);

    // Pause on step 3 with the counter at 2, resume ten cycles later.
    Loop = 1'b1; StepPeriod = 32'd4; Start = 1'b1;
    tick();
    ticks(14);
    check("prepause_Step", 32'(Step), 32'd3);
    Pause = 1'b1;
    tick();
    check("pause_Select",  32'(Select),  32'h0);
    check("pause_Step",    32'(Step),    32'd3);
    check("pause_nStart",  32'(nStart),  32'h1);
    check("pause_Playing", 32'(Playing), 32'h0);
    ticks(9);
    Start = 1'b1;
    tick();
    check("resume_Select",    32'(Select),    32'(m_pat[3]));
    check("resume_StepPulse", 32'(StepPulse), 32'h0);
    tick();
    check("resume_hold_Step", 32'(Step), 32'd3);
    tick();
    check("resume_step4_Step",  32'(Step),      32'd4);
    check("resume_step4_Pulse", 32'(StepPulse), 32'h1);

    // Edits: current step is not refreshed mid-step; entering step uses bypass.
    ticks(4);
    check("edit_on_step5", 32'(Step), 32'd5);
    old5 = m_pat[5];
    write_pat(5, 12'hFFF);
    check("edit_no_midstep_update", 32'(Select), 32'(old5));
    ticks(2);
    WrEn = 1'b1; WrStep = 4'd6; WrNotes = 12'hA5A; StepPeriod = 32'd4;
    tick();
    check("bypass_Step",   32'(Step),   32'd6);
    check("bypass_Select", 32'(Select), 32'hA5A);
    ticks(60);
    check("reentry5_Step",   32'(Step),   32'd5);
    check("reentry5_Select", 32'(Select), 32'hFFF);

    // Stop wins over a same-cycle Start.
    Stop = 1'b1; Start = 1'b1;
    tick();
    check("stopstart_nStart",  32'(nStart),  32'h0);
    check("stopstart_Playing", 32'(Playing), 32'h0);

    // Period 0 behaves as 1: a step and a pulse every cycle.
    StepPeriod = 32'd0; Start = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("p0_Step",  32'(Step),      32'(i));
      check("p0_Pulse", 32'(StepPulse), 32'h1);
    end

    // Asynchronous reset mid-step clears outputs at once and the pattern.
    StepPeriod = 32'd3;
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    check("areset_Select",    32'(Select),    32'h0);
    check("areset_nStart",    32'(nStart),    32'h0);
    check("areset_Step",      32'(Step),      32'h0);
    check("areset_StepPulse", 32'(StepPulse), 32'h0);
    check("areset_Playing",   32'(Playing),   32'h0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
    Loop = 1'b1; StepPeriod = 32'd2; Start = 1'b1;
    tick();
    check("cleared_Select", 32'(Select), 32'h0);
    for (int i = 1; i < 16; i++) begin
      ticks(2);
      check("cleared_Select", 32'(Select), 32'h0);
    end
    Stop = 1'b1;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      Start      = ($urandom_range(0, 9) == 0);
      Pause      = ($urandom_range(0, 19) == 0);
      Stop       = ($urandom_range(0, 39) == 0);
      Loop       = ($urandom_range(0, 3) != 0);
      StepPeriod = 32'($urandom_range(0, 4));
      WrEn       = ($urandom_range(0, 3) == 0);
      WrStep     = 4'($urandom);
      WrNotes    = 12'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Upstream stage of audio_generator: a 16-step, 12-note pattern sequencer for the piano step sequencer.
- Stores one 12-bit note mask per step and advances through the steps at a programmable tempo.
- Drives audio_generator's Select and nStart inputs.
- Provides a write port for the UI/keypad layer to edit the pattern while playing.

Parameters:
- STEPS, 16, number of pattern steps; must be a power of two.
- STEP_W, 4, step index width; equals log2(STEPS).
- CNT_W, 32, width of the tempo counter and of StepPeriod.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse: start from IDLE, or resume from PAUSED.
- Pause  in  1  one-cycle pulse: pause while RUN.
- Stop  in  1  one-cycle pulse: return to IDLE from any state.
- Loop  in  1  1 = wrap after the last step; 0 = go to IDLE after the last step.
- StepPeriod  in  CNT_W  Clock cycles per step; sampled at each step entry.
- WrEn  in  1  pattern write strobe.
- WrStep  in  STEP_W  step index to write.
- WrNotes  in  12  note mask to write; bit0 = C ... bit11 = B.
- Select  out  12  note mask for the current step, to audio_generator.
- nStart  out  1  low when IDLE, holding the oscillators in reset; high in RUN/PAUSED.
- Step  out  STEP_W  current step index.
- StepPulse  out  1  one-cycle pulse on each step entry.
- Playing  out  1  high in RUN only.

Behaviour:
- Reset (asynchronous, active-high) values:
  - state = IDLE.
  - Pattern memory all zero.
  - Counter = 0, Step = 0.
  - Select = 0, nStart = 0, StepPulse = 0, Playing = 0.
- Registers: pattern memory is STEPS x 12 flops. All outputs are registered.
- Input priority on the same cycle: Stop > Pause > Start. Pulses that are illegal in the current state are ignored.
- IDLE:
  - Start -> RUN.
  - Next cycle: Step = 0, Counter = 0, Select = pattern[0], StepPulse = 1, nStart = 1, Playing = 1.
  - Period latched from StepPeriod.
- RUN:
  - Counter increments every cycle.
  - When Counter == latched period - 1, on the next cycle:
    - Counter = 0.
    - Step = Step + 1, wrapping modulo STEPS.
    - Select = pattern[new Step], StepPulse = 1.
    - Period re-latched from StepPeriod.
  - StepPeriod of 0 is treated as 1: a step every cycle, with StepPulse held high continuously.
- End of pattern (step STEPS-1 expires):
  - Loop = 1: wrap to step 0, as above.
  - Loop = 0: go to IDLE with Step = 0, Select = 0, nStart = 0, Playing = 0, StepPulse = 0.
  - Loop is sampled on the expiry cycle.
- Pause in RUN -> PAUSED:
  - Counter and Step hold.
  - Select = 0 next cycle (silence); nStart stays 1; Playing = 0.
- Start in PAUSED -> RUN:
  - Select = pattern[Step] next cycle, Counter resumes from its held value.
  - No StepPulse on resume.
- Stop in RUN or PAUSED -> IDLE next cycle, with all outputs at their reset values. The pattern memory is preserved.
- Writes:
  - WrEn writes WrNotes to pattern[WrStep] in every state, including during reset release.
  - Select is not updated mid-step: a write to the current step takes effect on that step's next entry.
  - Write-first bypass: if WrEn targets the step being entered on the same cycle, Select takes WrNotes.
- A Start pulse in RUN is ignored; it does not restart the pattern.
- Reset asserted mid-play returns everything to reset values immediately (asynchronous). The pattern memory is also cleared.

Test Plan:
- Reset, write pattern[0] = 12'h001, pattern[1] = 12'h090, StepPeriod = 4, Loop = 1, Start:
  - Cycle +1: Select = 001, Step = 0, StepPulse = 1, nStart = 1.
  - Cycle +5: Select = 090, Step = 1.
  - After 16 steps: Step wraps to 0 with StepPulse.
- Loop = 0, StepPeriod = 2, Start:
  - After 32 cycles on step 15: IDLE, Select = 0, nStart = 0, Playing = 0.
- Pause on step 3 with Counter = 2 -> Select = 0, Step holds at 3, nStart = 1.
  - Start 10 cycles later -> Select = pattern[3], no StepPulse.
  - Step 4 arrives period - 2 cycles later.
- During step 5, write pattern[5] = 12'hFFF -> Select unchanged until step 5 re-entry.
  - Write to pattern[6] on the step-6 entry cycle -> Select = new value (bypass).
- Same-cycle Stop + Start in RUN -> IDLE.
  - StepPeriod = 0 -> StepPulse high every cycle and Step increments every cycle.
- Assert Reset mid-step -> all outputs 0 asynchronously (before the next Clock edge) and pattern cleared.
  - After release and Start, Select = 0 on every step.
